// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO data-port responder.
// Holds the peripheral register offsets inside the 8-byte MMIO window,
// the TCTRL/TSTAT bit positions and the default window base address.
package mmio_responder_pkg;

    // Default first peripheral address; the window is 8 bytes, aligned to 8.
    localparam logic [7:0] DEFAULT_MMIO_BASE = 8'hF8;

    // Register offsets within the window (address[2:0]).
    localparam logic [2:0] OFS_LED    = 3'd0;
    localparam logic [2:0] OFS_SW     = 3'd1;
    localparam logic [2:0] OFS_TLOAD  = 3'd2;
    localparam logic [2:0] OFS_TCOUNT = 3'd3;
    localparam logic [2:0] OFS_TCTRL  = 3'd4;
    localparam logic [2:0] OFS_TSTAT  = 3'd5;
    localparam logic [2:0] OFS_HEX_LO = 3'd6;
    localparam logic [2:0] OFS_HEX_HI = 3'd7;

    // TCTRL bit positions.
    localparam int TCTRL_EN_BIT = 0;
    localparam int TCTRL_AR_BIT = 1;

    // TSTAT bit positions.
    localparam int TSTAT_EXP_BIT = 0;

    // Builds the TCTRL read value; unused bits read as zero.
    function automatic logic [7:0] tctrl_word(input logic enable, input logic autoreload);
        tctrl_word = {6'b0, autoreload, enable};
    endfunction

endpackage

// File: rtl/mmio_responder_timer.sv
// mmio_timer: 8-bit down-counting timer with sticky expiry flag.
// Owns TLOAD, TCOUNT, TCTRL (enable/autoreload) and TSTAT (expired).
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   wr_en, rd_en       write / read strobes already qualified by the MMIO decode
//   ofs                register offset within the MMIO window
//   wdata              write data
//   tload, tcount      current TLOAD / TCOUNT values
//   enable, autoreload current TCTRL bits
//   expired            sticky expiry flag (TSTAT bit 0)
module mmio_timer
    import mmio_responder_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] ofs,
    input  logic [7:0] wdata,
    output logic [7:0] tload,
    output logic [7:0] tcount,
    output logic       enable,
    output logic       autoreload,
    output logic       expired
);

    logic [7:0] tload_reg, tload_next;
    logic [7:0] tcount_reg, tcount_next;
    logic       enable_reg, enable_next;
    logic       autoreload_reg, autoreload_next;
    logic       expired_reg, expired_next;
    logic       ctrl_wr;
    logic       start;
    logic       expired_set;
    logic       expired_clr;

    always_comb begin
        tload_next      = tload_reg;
        tcount_next     = tcount_reg;
        enable_next     = enable_reg;
        autoreload_next = autoreload_reg;
        ctrl_wr         = wr_en && (ofs == OFS_TCTRL);
        // A 0->1 enable transition reloads the count instead of ticking.
        start           = ctrl_wr && wdata[TCTRL_EN_BIT] && !enable_reg;
        expired_set     = 1'b0;
        expired_clr     = (wr_en && (ofs == OFS_TSTAT) && wdata[TSTAT_EXP_BIT]) ||
                          (rd_en && (ofs == OFS_TSTAT));

        if (start) begin
            tcount_next = tload_reg;
        end else if (enable_reg) begin
            if (tcount_reg != 8'd0) begin
                tcount_next = tcount_reg - 8'd1;
            end else begin
                expired_set = 1'b1;
                if (autoreload_reg) begin
                    tcount_next = tload_reg;
                end else begin
                    enable_next = 1'b0;
                end
            end
        end

        // An explicit TCTRL write overrides the one-shot self-disable.
        if (ctrl_wr) begin
            enable_next     = wdata[TCTRL_EN_BIT];
            autoreload_next = wdata[TCTRL_AR_BIT];
        end

        // A new TLOAD only matters at the next reload or start.
        if (wr_en && (ofs == OFS_TLOAD)) begin
            tload_next = wdata;
        end

        // Set wins over a same-cycle clear so no expiry is ever lost.
        expired_next = expired_set | (expired_reg & ~expired_clr);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tload_reg      <= 8'd0;
            tcount_reg     <= 8'd0;
            enable_reg     <= 1'b0;
            autoreload_reg <= 1'b0;
            expired_reg    <= 1'b0;
        end else begin
            tload_reg      <= tload_next;
            tcount_reg     <= tcount_next;
            enable_reg     <= enable_next;
            autoreload_reg <= autoreload_next;
            expired_reg    <= expired_next;
        end
    end

    assign tload      = tload_reg;
    assign tcount     = tcount_reg;
    assign enable     = enable_reg;
    assign autoreload = autoreload_reg;
    assign expired    = expired_reg;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: data-port responder between the processor data initiator
// and the 256x8 synchronous data RAM. Addresses MMIO_BASE..MMIO_BASE+7 hit
// peripheral registers (LED, SW, timer, HEX); everything else goes to RAM.
// Read data is returned with the same one-cycle latency as the RAM.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   MemRead, wren        processor read / write strobes
//   address, data        processor address and write data
//   q                    read data (valid the cycle after the MemRead edge)
//   ram_wren, ram_q      RAM write enable (gated) and RAM read data
//   sw                   raw asynchronous switches
//   leds, hex_value      LED register and {HEX_HI, HEX_LO}
//   timer_irq            level copy of the timer expired flag
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter logic [7:0] MMIO_BASE   = DEFAULT_MMIO_BASE,
    parameter int         SYNC_STAGES = 2
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        wren,
    input  logic [7:0]  address,
    input  logic [7:0]  data,
    output logic [7:0]  q,
    output logic        ram_wren,
    input  logic [7:0]  ram_q,
    input  logic [2:0]  sw,
    output logic [7:0]  leds,
    output logic [15:0] hex_value,
    output logic        timer_irq
);

    // Fewer than two stages would not give metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic       is_mmio;
    logic [2:0] ofs;
    logic       mmio_wr;
    logic       mmio_rd;
    logic [7:0] leds_reg;
    logic [7:0] hex_lo_reg;
    logic [7:0] hex_hi_reg;
    logic       sel_mmio_reg;
    logic [7:0] mmio_rdata_reg;
    logic [7:0] mmio_rdata_next;
    logic [2:0] sw_sync_reg [STAGES];
    logic [2:0] sw_stage_in [STAGES];
    logic [7:0] tload;
    logic [7:0] tcount;
    logic       t_enable;
    logic       t_autoreload;
    logic       t_expired;

    assign is_mmio = (address >= MMIO_BASE);
    assign ofs     = address[2:0];
    assign mmio_wr = wren && is_mmio;
    assign mmio_rd = MemRead && is_mmio;

    // RAM sees address/data directly; only its write enable is gated here.
    assign ram_wren = wren && !is_mmio && !reset;

    // Switch synchronizer: stage 0 samples the raw pins, later stages chain.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sw_stage_in[gi] = sw;
        end else begin : g_rest
            assign sw_stage_in[gi] = sw_sync_reg[gi-1];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) begin
                sw_sync_reg[i] <= 3'b000;
            end else begin
                sw_sync_reg[i] <= sw_stage_in[i];
            end
        end
    end

    mmio_timer u_timer (
        .clk        (clock),
        .srst       (reset),
        .wr_en      (mmio_wr),
        .rd_en      (mmio_rd),
        .ofs        (ofs),
        .wdata      (data),
        .tload      (tload),
        .tcount     (tcount),
        .enable     (t_enable),
        .autoreload (t_autoreload),
        .expired    (t_expired)
    );

    // Read mux uses pre-edge values, so reads see the state before any
    // same-cycle write, clear or decrement.
    always_comb begin
        mmio_rdata_next = 8'h00;
        case (ofs)
            OFS_LED:    mmio_rdata_next = leds_reg;
            OFS_SW:     mmio_rdata_next = {5'b0, sw_sync_reg[STAGES-1]};
            OFS_TLOAD:  mmio_rdata_next = tload;
            OFS_TCOUNT: mmio_rdata_next = tcount;
            OFS_TCTRL:  mmio_rdata_next = tctrl_word(t_enable, t_autoreload);
            OFS_TSTAT:  mmio_rdata_next = {7'b0, t_expired};
            OFS_HEX_LO: mmio_rdata_next = hex_lo_reg;
            OFS_HEX_HI: mmio_rdata_next = hex_hi_reg;
            default:    mmio_rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leds_reg       <= 8'h00;
            hex_lo_reg     <= 8'h00;
            hex_hi_reg     <= 8'h00;
            // Selecting the (zeroed) MMIO capture keeps q at 0 after reset
            // instead of exposing whatever the RAM output happens to be.
            sel_mmio_reg   <= 1'b1;
            mmio_rdata_reg <= 8'h00;
        end else begin
            if (mmio_wr && (ofs == OFS_LED)) begin
                leds_reg <= data;
            end
            if (mmio_wr && (ofs == OFS_HEX_LO)) begin
                hex_lo_reg <= data;
            end
            if (mmio_wr && (ofs == OFS_HEX_HI)) begin
                hex_hi_reg <= data;
            end
            if (MemRead) begin
                sel_mmio_reg   <= is_mmio;
                mmio_rdata_reg <= mmio_rdata_next;
            end
        end
    end

    assign q         = reset ? 8'h00 : (sel_mmio_reg ? mmio_rdata_reg : ram_q);
    assign leds      = leds_reg;
    assign hex_value = {hex_hi_reg, hex_lo_reg};
    assign timer_irq = t_expired;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: a table of per-cycle vectors
// followed by hand-written sequences for switch sync and reset.
module tb_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        wren;
    logic [7:0]  address;
    logic [7:0]  data;
    logic [7:0]  q;
    logic        ram_wren;
    logic [7:0]  ram_q;
    logic [2:0]  sw;
    logic [7:0]  leds;
    logic [15:0] hex_value;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mmio_responder dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .wren      (wren),
        .address   (address),
        .data      (data),
        .q         (q),
        .ram_wren  (ram_wren),
        .ram_q     (ram_q),
        .sw        (sw),
        .leds      (leds),
        .hex_value (hex_value),
        .timer_irq (timer_irq)
    );

    // Behavioural synchronous RAM: registered read returns pre-write data.
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
    end
    always @(posedge clock) begin
        if (ram_wren) mem[address] <= data;
        if (MemRead)  ram_q <= mem[address];
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        chk_q;
        logic [7:0]  exp_q;
        logic        exp_ram_wren;
        logic [7:0]  exp_leds;
        logic [15:0] exp_hex;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wd, input logic chk, input logic [7:0] eq,
                                input logic erw, input logic [7:0] el, input logic [15:0] eh,
                                input logic ei);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
        v.chk_q = chk; v.exp_q = eq; v.exp_ram_wren = erw;
        v.exp_leds = el; v.exp_hex = eh; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        MemRead = rd;
        wren    = wr;
        address = a;
        data    = d;
    endtask

    initial begin
        // rd wr addr wdata chk_q exp_q ram_wren leds hex irq
        // RAM pass-through, LED, HEX, RO write
        vecs.push_back(mk(0,1,8'h10,8'h3C,0,8'h00,1,8'h00,16'h0000,0)); // 0
        vecs.push_back(mk(0,1,8'hF8,8'h55,0,8'h00,0,8'h55,16'h0000,0)); // 1
        vecs.push_back(mk(1,0,8'h10,8'h00,1,8'h3C,0,8'h55,16'h0000,0)); // 2
        vecs.push_back(mk(1,0,8'hF8,8'h00,1,8'h55,0,8'h55,16'h0000,0)); // 3
        vecs.push_back(mk(0,1,8'hFE,8'hCD,0,8'h00,0,8'h55,16'h00CD,0)); // 4
        vecs.push_back(mk(0,1,8'hFF,8'hAB,0,8'h00,0,8'h55,16'hABCD,0)); // 5
        vecs.push_back(mk(1,0,8'hFE,8'h00,1,8'hCD,0,8'h55,16'hABCD,0)); // 6
        vecs.push_back(mk(0,1,8'hFB,8'h77,0,8'h00,0,8'h55,16'hABCD,0)); // 7 TCOUNT write ignored
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h00,0,8'h55,16'hABCD,0)); // 8
        // one-shot: TLOAD=3, enable
        vecs.push_back(mk(0,1,8'hFA,8'h03,0,8'h00,0,8'h55,16'hABCD,0)); // 9
        vecs.push_back(mk(0,1,8'hFC,8'h01,0,8'h00,0,8'h55,16'hABCD,0)); // 10
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h03,0,8'h55,16'hABCD,0)); // 11
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h02,0,8'h55,16'hABCD,0)); // 12
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h01,0,8'h55,16'hABCD,0)); // 13
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h00,0,8'h55,16'hABCD,1)); // 14 expiry
        vecs.push_back(mk(1,0,8'hFC,8'h00,1,8'h00,0,8'h55,16'hABCD,1)); // 15 enable cleared
        vecs.push_back(mk(1,0,8'hFD,8'h00,1,8'h01,0,8'h55,16'hABCD,0)); // 16 read clears
        vecs.push_back(mk(1,0,8'hFD,8'h00,1,8'h00,0,8'h55,16'hABCD,0)); // 17
        // autoreload: TLOAD=1, TCTRL=3
        vecs.push_back(mk(0,1,8'hFA,8'h01,0,8'h00,0,8'h55,16'hABCD,0)); // 18
        vecs.push_back(mk(0,1,8'hFC,8'h03,0,8'h00,0,8'h55,16'hABCD,0)); // 19
        vecs.push_back(mk(0,0,8'h00,8'h00,0,8'h00,0,8'h55,16'hABCD,0)); // 20
        vecs.push_back(mk(0,0,8'h00,8'h00,0,8'h00,0,8'h55,16'hABCD,1)); // 21
        vecs.push_back(mk(1,0,8'hFD,8'h00,1,8'h01,0,8'h55,16'hABCD,0)); // 22
        vecs.push_back(mk(0,0,8'h00,8'h00,0,8'h00,0,8'h55,16'hABCD,1)); // 23
        vecs.push_back(mk(0,1,8'hFD,8'h01,0,8'h00,0,8'h55,16'hABCD,0)); // 24 W1C
        vecs.push_back(mk(1,0,8'hFD,8'h00,1,8'h00,0,8'h55,16'hABCD,1)); // 25 read clear on expiry
        vecs.push_back(mk(0,0,8'h00,8'h00,0,8'h00,0,8'h55,16'hABCD,1)); // 26
        vecs.push_back(mk(0,1,8'hFD,8'h01,0,8'h00,0,8'h55,16'hABCD,1)); // 27 W1C on expiry
        vecs.push_back(mk(0,1,8'hFD,8'h01,0,8'h00,0,8'h55,16'hABCD,0)); // 28
        vecs.push_back(mk(0,1,8'hFC,8'h00,0,8'h00,0,8'h55,16'hABCD,1)); // 29 stop (expires)
        vecs.push_back(mk(1,0,8'hFB,8'h00,1,8'h01,0,8'h55,16'hABCD,1)); // 30 count held
        vecs.push_back(mk(1,0,8'hFD,8'h00,1,8'h01,0,8'h55,16'hABCD,0)); // 31
        // TCTRL upper bits read as zero
        vecs.push_back(mk(0,1,8'hFC,8'hFF,0,8'h00,0,8'h55,16'hABCD,0)); // 32
        vecs.push_back(mk(1,0,8'hFC,8'h00,1,8'h03,0,8'h55,16'hABCD,0)); // 33
        vecs.push_back(mk(0,1,8'hFC,8'h00,0,8'h00,0,8'h55,16'hABCD,1)); // 34
        vecs.push_back(mk(0,1,8'hFD,8'h01,0,8'h00,0,8'h55,16'hABCD,0)); // 35
        // simultaneous read+write returns pre-write contents
        vecs.push_back(mk(1,1,8'h10,8'h99,1,8'h3C,1,8'h55,16'hABCD,0)); // 36
        vecs.push_back(mk(1,0,8'h10,8'h00,1,8'h99,0,8'h55,16'hABCD,0)); // 37
        vecs.push_back(mk(1,1,8'hF8,8'h11,1,8'h55,0,8'h11,16'hABCD,0)); // 38
        vecs.push_back(mk(0,0,8'h00,8'h00,1,8'h55,0,8'h11,16'hABCD,0)); // 39 q holds

        // Reset state
        reset = 1'b1;
        sw    = 3'b000;
        drive(0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", {8'h00, q}, 16'h0000);
        check("reset_leds", {8'h00, leds}, 16'h0000);
        check("reset_hex", hex_value, 16'h0000);
        check("reset_irq", {15'h0, timer_irq}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_q", {8'h00, q}, 16'h0000);
        $display("reset sequence done");

        // Table-driven vectors, one cycle each
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_ram_wren", i), {15'h0, ram_wren}, {15'h0, vecs[i].exp_ram_wren});
            @(posedge clock);
            #1;
            if (vecs[i].chk_q)
                check($sformatf("v%0d_q", i), {8'h00, q}, {8'h00, vecs[i].exp_q});
            check($sformatf("v%0d_leds", i), {8'h00, leds}, {8'h00, vecs[i].exp_leds});
            check($sformatf("v%0d_hex", i), hex_value, vecs[i].exp_hex);
            check($sformatf("v%0d_irq", i), {15'h0, timer_irq}, {15'h0, vecs[i].exp_irq});
            $display("vec %0d rd=%b wr=%b addr=%h data=%h -> q=%h leds=%h hex=%h irq=%b",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                     q, leds, hex_value, timer_irq);
        end

        // Switch synchronizer: back-to-back SW reads after sw changes
        @(negedge clock);
        sw = 3'b101;
        drive(1, 0, 8'hF9, 8'h00);
        @(posedge clock); #1;
        check("sw_edge1", {8'h00, q}, 16'h0000);
        @(posedge clock); #1;
        check("sw_edge2", {8'h00, q}, 16'h0000);
        @(posedge clock); #1;
        check("sw_edge3", {8'h00, q}, 16'h0005);
        $display("switch sequence q=%h", q);

        // Dirty the state: timer free-running with TLOAD=0, q showing LED
        @(negedge clock); drive(0, 1, 8'hFA, 8'h00);
        @(negedge clock); drive(0, 1, 8'hFC, 8'h03);
        @(negedge clock); drive(1, 0, 8'hF8, 8'h00);
        @(negedge clock); drive(0, 0, 8'h00, 8'h00);
        @(posedge clock); #1;
        check("dirty_irq", {15'h0, timer_irq}, 16'h0001);
        check("dirty_q", {8'h00, q}, 16'h0011);

        // Reset mid-operation, with a RAM write pending during reset
        @(negedge clock);
        reset = 1'b1;
        drive(0, 1, 8'h10, 8'h42);
        #1;
        check("reset_ram_wren", {15'h0, ram_wren}, 16'h0000);
        check("reset_q_comb", {8'h00, q}, 16'h0000);
        @(posedge clock); #1;
        check("rst2_leds", {8'h00, leds}, 16'h0000);
        check("rst2_hex", hex_value, 16'h0000);
        check("rst2_irq", {15'h0, timer_irq}, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 0, 8'hFC, 8'h00);
        @(posedge clock); #1;
        check("rst2_tctrl", {8'h00, q}, 16'h0000);
        @(negedge clock); drive(0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        check("rst2_irq_after", {15'h0, timer_irq}, 16'h0000);
        $display("reset mid-operation sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
